// File: rtl/reg_file_3port.sv
// 32x32 register file: two combinational read ports, one synchronous write port, r0 hardwired to zero.
// Optional write-through bypass on the read ports when REG_FILE_BYPASS_EN is defined.
module reg_file_3port #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] A1,
    input  logic [ADDR_WIDTH-1:0] A2,
    input  logic [ADDR_WIDTH-1:0] A3,
    input  logic [DATA_WIDTH-1:0] WD,
    input  logic                  WE,
    output logic [DATA_WIDTH-1:0] RD1,
    output logic [DATA_WIDTH-1:0] RD2
);
    localparam int NREGS = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs [NREGS];
    logic                  wr_en;

    // r0 is never written, so it stays at its reset value; reads still mask it
    // so it is zero even before the first reset.
    assign wr_en = WE && (A3 != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else if (wr_en) begin
            regs[A3] <= WD;
        end
    end

`ifdef REG_FILE_BYPASS_EN
    logic hit1, hit2;
    assign hit1 = wr_en && !rst && (A1 == A3);
    assign hit2 = wr_en && !rst && (A2 == A3);

    always_comb begin
        RD1 = '0;
        RD2 = '0;
        if (A1 != '0) RD1 = hit1 ? WD : regs[A1];
        if (A2 != '0) RD2 = hit2 ? WD : regs[A2];
    end
`else
    always_comb begin
        RD1 = '0;
        RD2 = '0;
        if (A1 != '0) RD1 = regs[A1];
        if (A2 != '0) RD2 = regs[A2];
    end
`endif
endmodule

// File: tb/tb_reg_file_3port.sv
// Self-checking bench for reg_file_3port: reference model feeds expected-value queues,
// which are popped and compared against RD1/RD2 after each read setup.
module tb_reg_file_3port;
    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  A1, A2, A3;
    logic [31:0] WD;
    logic        WE;
    logic [31:0] RD1, RD2;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] model [32];
    logic [31:0] q1 [$];
    logic [31:0] q2 [$];
    logic [31:0] e1, e2;

    reg_file_3port #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
        .clk(clk), .rst(rst), .A1(A1), .A2(A2), .A3(A3),
        .WD(WD), .WE(WE), .RD1(RD1), .RD2(RD2)
    );

    always #5 clk = ~clk;

    // Advance one rising edge, updating the model with what the DUT samples there.
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 32; i++) model[i] = 32'h0;
        end else if (WE && A3 != 5'd0) begin
            model[A3] = WD;
        end
        #1;
    endtask

    task automatic push_exp();
        q1.push_back(A1 == 5'd0 ? 32'h0 : model[A1]);
        q2.push_back(A2 == 5'd0 ? 32'h0 : model[A2]);
    endtask

    task automatic do_write(input logic [4:0] a, input logic [31:0] d);
        WE = 1'b1; A3 = a; WD = d;
        tick();
        WE = 1'b0;
    endtask

    task automatic test_reset();
        logic [4:0] addrs [4];
        addrs = '{5'd0, 5'd1, 5'd26, 5'd31};
        do_write(5'd1, 32'hDEADBEEF);
        do_write(5'd26, 32'hCAFEF00D);
        do_write(5'd31, 32'h13572468);
        WE = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            A1 = addrs[i]; A2 = addrs[i];
            push_exp(); #1;
            e1 = q1.pop_front(); e2 = q2.pop_front();
            n_tests += 2;
            if (RD1 !== e1 || e1 !== 32'h0) begin n_fail++; $display("FAIL reset_rd1 a=%0d got %h exp 0", A1, RD1); end
            if (RD2 !== e2 || e2 !== 32'h0) begin n_fail++; $display("FAIL reset_rd2 a=%0d got %h exp 0", A2, RD2); end
        end
        // reset wins over a same-edge write
        rst = 1'b1; WE = 1'b1; A3 = 5'd1; WD = 32'h55AA55AA;
        tick();
        rst = 1'b0; WE = 1'b0;
        A1 = 5'd1; A2 = 5'd1;
        push_exp(); #1;
        e1 = q1.pop_front(); e2 = q2.pop_front();
        n_tests += 2;
        if (RD1 !== e1) begin n_fail++; $display("FAIL reset_prio_rd1 got %h exp %h", RD1, e1); end
        if (RD2 !== e2) begin n_fail++; $display("FAIL reset_prio_rd2 got %h exp %h", RD2, e2); end
    endtask

    task automatic test_basic();
        do_write(5'd26, 32'h8FFAF3BD);
        A2 = 5'd26; A1 = 5'd0;
        push_exp(); #1;
        e1 = q1.pop_front(); e2 = q2.pop_front();
        n_tests += 2;
        if (RD2 !== e2 || e2 !== 32'h8FFAF3BD) begin n_fail++; $display("FAIL basic_rd2 got %h exp 8ffaf3bd", RD2); end
        if (RD1 !== e1) begin n_fail++; $display("FAIL basic_rd1_r0 got %h exp %h", RD1, e1); end
    endtask

    task automatic test_zero_reg();
        do_write(5'd0, 32'hFFFFFFFF);
        A1 = 5'd0; A2 = 5'd26;
        push_exp(); #1;
        e1 = q1.pop_front(); e2 = q2.pop_front();
        n_tests += 2;
        if (RD1 !== e1 || e1 !== 32'h0) begin n_fail++; $display("FAIL zero_reg got %h exp 0", RD1); end
        if (RD2 !== e2) begin n_fail++; $display("FAIL zero_reg_other got %h exp %h", RD2, e2); end
    endtask

    task automatic test_we_gating();
        WE = 1'b0; A3 = 5'd5; WD = 32'h12345678;
        tick();
        WD = 32'h87654321;
        tick();
        A3 = 5'd26; WD = 32'h0BADF00D;
        tick();
        A1 = 5'd5; A2 = 5'd26;
        push_exp(); #1;
        e1 = q1.pop_front(); e2 = q2.pop_front();
        n_tests += 2;
        if (RD1 !== e1 || e1 !== 32'h0) begin n_fail++; $display("FAIL we_gate_r5 got %h exp 0", RD1); end
        if (RD2 !== e2) begin n_fail++; $display("FAIL we_gate_r26 got %h exp %h", RD2, e2); end
    endtask

    task automatic test_dual_overwrite();
        do_write(5'd31, 32'hAAAA5555);
        do_write(5'd31, 32'h0000FFFF);
        A1 = 5'd31; A2 = 5'd31;
        push_exp(); #1;
        e1 = q1.pop_front(); e2 = q2.pop_front();
        n_tests += 2;
        if (RD1 !== e1 || e1 !== 32'h0000FFFF) begin n_fail++; $display("FAIL dual_rd1 got %h exp 0000ffff", RD1); end
        if (RD2 !== e2 || e2 !== 32'h0000FFFF) begin n_fail++; $display("FAIL dual_rd2 got %h exp 0000ffff", RD2); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        push_exp(); #1;
        e1 = q1.pop_front(); e2 = q2.pop_front();
        n_tests += 2;
        if (RD1 !== e1 || e1 !== 32'h0) begin n_fail++; $display("FAIL dual_rst_rd1 got %h exp 0", RD1); end
        if (RD2 !== e2 || e2 !== 32'h0) begin n_fail++; $display("FAIL dual_rst_rd2 got %h exp 0", RD2); end
    endtask

    task automatic test_rdw();
        do_write(5'd7, 32'h11111111);
        WE = 1'b1; A3 = 5'd7; WD = 32'h22222222; A1 = 5'd7; A2 = 5'd7;
`ifdef REG_FILE_BYPASS_EN
        q1.push_back(32'h22222222);
        q2.push_back(32'h22222222);
`else
        q1.push_back(model[7]);
        q2.push_back(model[7]);
`endif
        #1;
        e1 = q1.pop_front(); e2 = q2.pop_front();
        n_tests += 2;
        if (RD1 !== e1) begin n_fail++; $display("FAIL rdw_before_rd1 got %h exp %h", RD1, e1); end
        if (RD2 !== e2) begin n_fail++; $display("FAIL rdw_before_rd2 got %h exp %h", RD2, e2); end
        tick();
        WE = 1'b0;
        push_exp(); #1;
        e1 = q1.pop_front(); e2 = q2.pop_front();
        n_tests += 2;
        if (RD1 !== e1 || e1 !== 32'h22222222) begin n_fail++; $display("FAIL rdw_after_rd1 got %h exp 22222222", RD1); end
        if (RD2 !== e2) begin n_fail++; $display("FAIL rdw_after_rd2 got %h exp %h", RD2, e2); end
    endtask

    initial begin
        rst = 1'b1; WE = 1'b0; A1 = '0; A2 = '0; A3 = '0; WD = '0;
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
        tick();
        rst = 1'b0;
        test_reset();
        test_basic();
        test_zero_reg();
        test_we_gating();
        test_dual_overwrite();
        test_rdw();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
